// File: rtl/beam_scaler_pkg.sv
// Shared definitions for the beam scaler readout block.
//   state_t      : readout sequencer states
//   SCALER_BITS  : width of a stored (saturated) scaler count
//   SAT_BIT      : read-word bit carrying the saturation flag
//   VALID_BIT    : status-word bit carrying the bank-valid flag
//   SEQ_BITS     : width of the period sequence counter
//   saturate()   : clamps a raw 48-bit count to a 25-bit {sat, count24} entry
//   status_addr(): register address of the status word
package beam_scaler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_READ,
    ST_DRAIN,
    ST_SWAP
  } state_t;

  localparam int unsigned SCALER_BITS = 24;
  localparam int unsigned ENTRY_BITS  = SCALER_BITS + 1;
  localparam int unsigned SAT_BIT     = 31;
  localparam int unsigned VALID_BIT   = 31;
  localparam int unsigned SEQ_BITS    = 16;

  function automatic logic [ENTRY_BITS-1:0] saturate(input logic [47:0] count);
    logic [ENTRY_BITS-1:0] entry;
    if (count[47:SCALER_BITS] != '0) entry = {1'b1, {SCALER_BITS{1'b1}}};
    else                             entry = {1'b0, count[SCALER_BITS-1:0]};
    return entry;
  endfunction

  // The status register sits directly above the last beam register.
  function automatic int unsigned status_addr(input int unsigned nbeams);
    return nbeams;
  endfunction

endpackage

// File: rtl/beam_scaler_bank.sv
// Double-buffered scaler storage: two banks of NBEAMS x 25-bit entries.
//   ifclk   : clock
//   rst_ni  : asynchronous active-low reset (bank select only; RAM not reset)
//   we      : write enable into the back bank
//   wr_idx  : beam index to write
//   wr_data : {sat, count24} entry
//   flip    : exchange front and back banks at the end of this cycle
//   rd_idx  : beam index to read from the front bank
//   rd_data : registered read data (front bank)
module beam_scaler_bank
  import beam_scaler_pkg::*;
#(
  parameter int unsigned NBEAMS = 48
) (
  input  logic                          ifclk,
  input  logic                          rst_ni,
  input  logic                          we,
  input  logic [$clog2(NBEAMS)-1:0]     wr_idx,
  input  logic [ENTRY_BITS-1:0]         wr_data,
  input  logic                          flip,
  input  logic [$clog2(NBEAMS)-1:0]     rd_idx,
  output logic [ENTRY_BITS-1:0]         rd_data
);

  // Power-of-two depth so any rd_idx value stays inside the array.
  localparam int unsigned DEPTH = 2 ** $clog2(NBEAMS);

  logic [ENTRY_BITS-1:0] mem [2][DEPTH];
  logic                  front;

  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni)   front <= 1'b0;
    else if (flip) front <= ~front;
  end

  always_ff @(posedge ifclk) begin
    if (we) mem[~front][wr_idx] <= wr_data;
    rd_data <= mem[front][rd_idx];
  end

endmodule

// File: rtl/beam_scaler_readout.sv
// Periodic reader for the per-beam trigger scalers. Times a gate period,
// strobes the counters, walks the select mux over all beams, captures the
// saturated counts into the back bank and swaps banks once per period.
//   ifclk    : clock
//   rst_ni   : asynchronous active-low reset
//   en_i     : run enable
//   update_o : one-cycle latch/restart strobe to the counters
//   sel_o    : beam select to the counter mux
//   count_i  : selected counter value, RD_LATENCY cycles after sel_o
//   stb_i    : register read request
//   adr_i    : register address (beams 0..NBEAMS-1, status at NBEAMS)
//   dat_o    : read data, valid with ack_o, zero otherwise
//   ack_o    : one-cycle read acknowledge, the cycle after stb_i
module beam_scaler_readout
  import beam_scaler_pkg::*;
#(
  parameter int unsigned NBEAMS      = 48,
  parameter int unsigned PERIOD_CLKS = 1000000,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                          ifclk,
  input  logic                          rst_ni,
  input  logic                          en_i,
  output logic                          update_o,
  output logic [$clog2(NBEAMS)-1:0]     sel_o,
  input  logic [47:0]                   count_i,
  input  logic                          stb_i,
  input  logic [$clog2(NBEAMS+1)-1:0]   adr_i,
  output logic [31:0]                   dat_o,
  output logic                          ack_o
);

  localparam int unsigned SW = $clog2(NBEAMS);
  localparam int unsigned AW = $clog2(NBEAMS + 1);
  localparam int unsigned TW = $clog2(PERIOD_CLKS);
  localparam int unsigned DW = $clog2(RD_LATENCY + 1);

  localparam logic [SW-1:0] LAST_SEL = SW'(NBEAMS - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(PERIOD_CLKS - 1);
  localparam logic [DW-1:0] LAST_D   = DW'(RD_LATENCY - 1);
  localparam logic [AW-1:0] STAT_ADR = AW'(status_addr(NBEAMS));
  localparam logic [AW-1:0] N_ADR    = AW'(NBEAMS);

  state_t                state, state_nx;
  logic [TW-1:0]         timer;
  logic                  timer_last;
  logic [DW-1:0]         drain_cnt;
  logic [SEQ_BITS-1:0]   seq;
  logic                  valid;
  logic                  swap;

  logic [RD_LATENCY-1:0] cap_vld;
  logic [SW-1:0]         cap_idx [RD_LATENCY];

  logic [ENTRY_BITS-1:0] rd_entry;
  logic                  rd_beam, rd_stat;
  logic [31:0]           stat_word, stat_q;

  assign timer_last = (timer == LAST_T);

  // State register
  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (en_i) state_nx = ST_GATE;
      ST_GATE:  if (!en_i) state_nx = ST_IDLE;
                else if (timer_last) state_nx = ST_READ;
      ST_READ:  if (sel_o == LAST_SEL) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == LAST_D) state_nx = ST_SWAP;
      ST_SWAP:  state_nx = en_i ? ST_GATE : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    update_o = (state == ST_GATE) && en_i && timer_last;
    swap     = (state == ST_SWAP);
  end

  // Free-running period timer: cleared while idle (and on the way into idle)
  // so the first gate cycle sees 0, otherwise wraps across READ/DRAIN/SWAP.
  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni)                                    timer <= '0;
    else if (state == ST_IDLE || state_nx == ST_IDLE) timer <= '0;
    else if (timer_last)                            timer <= '0;
    else                                            timer <= timer + 1'b1;
  end

  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_o     <= '0;
      drain_cnt <= '0;
      seq       <= '0;
      valid     <= 1'b0;
    end else begin
      if (state == ST_READ && sel_o != LAST_SEL) sel_o <= sel_o + 1'b1;
      else if (swap)                             sel_o <= '0;
      if (state == ST_READ)       drain_cnt <= '0;
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (swap) begin
        seq   <= seq + 1'b1;
        valid <= 1'b1;
      end
    end
  end

  // Delay the select index by the counter-mux latency to form write strobes.
  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) cap_idx[i] <= '0;
    end else begin
      cap_vld[0] <= (state == ST_READ);
      cap_idx[0] <= sel_o;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        cap_vld[i] <= cap_vld[i-1];
        cap_idx[i] <= cap_idx[i-1];
      end
    end
  end

  beam_scaler_bank #(
    .NBEAMS (NBEAMS)
  ) u_bank (
    .ifclk   (ifclk),
    .rst_ni  (rst_ni),
    .we      (cap_vld[RD_LATENCY-1]),
    .wr_idx  (cap_idx[RD_LATENCY-1]),
    .wr_data (saturate(count_i)),
    .flip    (swap),
    .rd_idx  (adr_i[SW-1:0]),
    .rd_data (rd_entry)
  );

  always_comb begin
    stat_word                 = '0;
    stat_word[VALID_BIT]      = valid;
    stat_word[SEQ_BITS-1:0]   = seq;
  end

  // Read port: decode flags and status are registered with the bank read so
  // a request sampled in the SWAP cycle sees the old bank, seq and valid.
  always_ff @(posedge ifclk or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o   <= 1'b0;
      rd_beam <= 1'b0;
      rd_stat <= 1'b0;
      stat_q  <= '0;
    end else begin
      ack_o   <= stb_i;
      rd_beam <= stb_i && valid && (adr_i < N_ADR);
      rd_stat <= stb_i && (adr_i == STAT_ADR);
      stat_q  <= stat_word;
    end
  end

  always_comb begin
    dat_o = '0;
    if (ack_o && rd_beam) begin
      dat_o[SAT_BIT]           = rd_entry[SCALER_BITS];
      dat_o[SCALER_BITS-1:0]   = rd_entry[SCALER_BITS-1:0];
    end else if (ack_o && rd_stat) begin
      dat_o = stat_q;
    end
  end

endmodule

// File: tb/tb_beam_scaler_readout.sv
module tb_beam_scaler_readout;

  localparam int unsigned NB  = 4;
  localparam int unsigned PER = 20;
  localparam int unsigned RL  = 2;

  logic        ifclk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        update_o;
  logic [1:0]  sel_o;
  logic [47:0] count_i;
  logic        stb_i;
  logic [2:0]  adr_i;
  logic [31:0] dat_o;
  logic        ack_o;

  int n_checks = 0;
  int n_errors = 0;

  // Counter mux model: value base+sel, delivered RL cycles after sel_o.
  int          base = 100;
  bit          sat_mode = 1'b0;
  logic [1:0]  sel_d1 = '0, sel_d2 = '0;
  int          cyc = 0;
  bit          gap_en = 1'b0, have_last = 1'b0;
  int          last_upd = 0;

  beam_scaler_readout #(
    .NBEAMS      (NB),
    .PERIOD_CLKS (PER),
    .RD_LATENCY  (RL)
  ) dut (
    .ifclk    (ifclk),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .update_o (update_o),
    .sel_o    (sel_o),
    .count_i  (count_i),
    .stb_i    (stb_i),
    .adr_i    (adr_i),
    .dat_o    (dat_o),
    .ack_o    (ack_o)
  );

  always #5 ifclk = ~ifclk;

  always @(posedge ifclk) begin
    sel_d1 <= sel_o;
    sel_d2 <= sel_d1;
    cyc    <= cyc + 1;
  end

  assign count_i = (sat_mode && sel_d2 == 2'd2) ? 48'h1_000000
                                                : 48'(base) + 48'(sel_d2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Update spacing monitor, active only while gap_en is set.
  always @(negedge ifclk) begin
    if (!gap_en) have_last = 1'b0;
    else if (update_o) begin
      if (have_last) chk("upd_gap", 64'(cyc - last_upd), 64'(PER));
      last_upd  = cyc;
      have_last = 1'b1;
    end
  end

  task automatic wait_negs(input int n);
    repeat (n) @(negedge ifclk);
  endtask

  // Returns at the negedge of the update cycle; n = negedges waited.
  task automatic wait_update(input string tag, output int n);
    n = 0;
    do begin
      @(negedge ifclk);
      n++;
    end while (!update_o && n < 60);
    chk({tag, "_seen"}, 64'(update_o), 64'd1);
  endtask

  task automatic count_upd(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge ifclk);
      if (update_o) n++;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    stb_i = 1'b1;
    adr_i = a;
    @(negedge ifclk);
    chk(tag, {31'b0, ack_o, dat_o}, {31'b0, 1'b1, exp});
    stb_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    en_i   = 1'b0;
    stb_i  = 1'b0;
    adr_i  = '0;
    wait_negs(3);
    chk("rst_update", 64'(update_o), 64'd0);
    chk("rst_sel",    64'(sel_o),    64'd0);
    chk("rst_ack",    64'(ack_o),    64'd0);
    chk("rst_dat",    64'(dat_o),    64'd0);
    rst_ni = 1'b1;
    @(negedge ifclk);
    rd_chk("pre_stat",  3'd4, 32'h0);
    rd_chk("pre_beam0", 3'd0, 32'h0);

    // Period 1: first update after exactly PER cycles, then sel walk.
    en_i = 1'b1;
    wait_update("upd1", n);
    chk("upd1_lat", 64'(n), 64'(PER));
    for (int k = 0; k < NB; k++) begin
      @(negedge ifclk);
      chk($sformatf("sel_step%0d", k), 64'(sel_o), 64'(k));
    end
    @(negedge ifclk);
    chk("sel_drain", 64'(sel_o), 64'(NB - 1));
    wait_negs(2);
    chk("sel_swap", 64'(sel_o), 64'(NB - 1));
    // status read sampled in the SWAP cycle, then held one more cycle
    stb_i = 1'b1;
    adr_i = 3'd4;
    @(negedge ifclk);
    chk("swap_stat_old", {31'b0, ack_o, dat_o}, {31'b0, 1'b1, 32'h0});
    chk("sel_after_swap", 64'(sel_o), 64'd0);
    @(negedge ifclk);
    chk("swap_stat_new", {31'b0, ack_o, dat_o}, {31'b0, 1'b1, 32'h8000_0001});
    stb_i = 1'b0;
    @(negedge ifclk);
    chk("ack_low", {31'b0, ack_o, dat_o}, 64'd0);
    for (int k = 0; k < NB; k++)
      rd_chk($sformatf("p1_beam%0d", k), 3'(k), 32'(100 + k));

    // Period 2: new base, beam 2 saturates; read beam 0 across the swap.
    base     = 200;
    sat_mode = 1'b1;
    wait_update("upd2", n);
    wait_negs(7);
    stb_i = 1'b1;
    adr_i = 3'd0;
    @(negedge ifclk);
    chk("swap_beam0_old", {31'b0, ack_o, dat_o}, {31'b0, 1'b1, 32'd100});
    @(negedge ifclk);
    chk("swap_beam0_new", {31'b0, ack_o, dat_o}, {31'b0, 1'b1, 32'd200});
    stb_i = 1'b0;
    rd_chk("p2_beam1", 3'd1, 32'd201);
    rd_chk("p2_beam2_sat", 3'd2, 32'h80FF_FFFF);
    rd_chk("p2_beam3", 3'd3, 32'd203);
    rd_chk("p2_stat", 3'd4, 32'h8000_0002);

    // Back-to-back periods over a 200-cycle window.
    base     = 300;
    sat_mode = 1'b0;
    wait_update("upd3", n);
    wait_negs(8);
    rd_chk("p3_stat", 3'd4, 32'h8000_0003);
    gap_en = 1'b1;
    count_upd(200, n);
    gap_en = 1'b0;
    chk("upd_in_200", 64'(n), 64'd10);
    rd_chk("seq_after_200", 3'd4, 32'h8000_000D);

    // Enable dropped mid-READ: readout still swaps, then idles.
    wait_update("upd4", n);
    wait_negs(2);
    en_i = 1'b0;
    wait_negs(6);
    chk("sel_idle", 64'(sel_o), 64'd0);
    rd_chk("drop_read_stat", 3'd4, 32'h8000_000E);
    rd_chk("drop_read_beam1", 3'd1, 32'd301);
    count_upd(40, n);
    chk("no_upd_after_read_drop", 64'(n), 64'd0);

    // Enable dropped during GATE: no strobe at all.
    en_i = 1'b1;
    wait_negs(10);
    en_i = 1'b0;
    count_upd(40, n);
    chk("no_upd_after_gate_drop", 64'(n), 64'd0);
    rd_chk("gate_drop_stat", 3'd4, 32'h8000_000E);

    // Reset asserted mid-READ with a read in flight.
    en_i = 1'b1;
    wait_update("upd5", n);
    chk("upd5_lat", 64'(n), 64'(PER));
    stb_i = 1'b1;
    adr_i = 3'd4;
    @(negedge ifclk);
    chk("pre_rst_read", {31'b0, ack_o, dat_o}, {31'b0, 1'b1, 32'h8000_000E});
    @(negedge ifclk);
    chk("pre_rst_sel", 64'(sel_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_update", 64'(update_o), 64'd0);
    chk("mid_rst_sel",    64'(sel_o),    64'd0);
    chk("mid_rst_ack",    64'(ack_o),    64'd0);
    chk("mid_rst_dat",    64'(dat_o),    64'd0);
    stb_i = 1'b0;
    en_i  = 1'b0;
    @(negedge ifclk);
    rst_ni = 1'b1;
    @(negedge ifclk);
    rd_chk("post_rst_stat",  3'd4, 32'h0);
    rd_chk("post_rst_beam0", 3'd0, 32'h0);
    en_i = 1'b1;
    wait_update("upd6", n);
    chk("upd6_lat", 64'(n), 64'(PER));
    wait_negs(8);
    rd_chk("post_rst_new_beam0", 3'd0, 32'd300);
    rd_chk("post_rst_new_stat",  3'd4, 32'h8000_0001);
    en_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
